relu_serializer: RTL and testbench
==================================

# relu_serializer

Downstream stage of a linear layer: captures the NUM_NODES-wide parallel result vector on a single valid pulse and applies ReLU (optional). It then streams the elements out one per cycle, index 0 first, in the din/i_valid format that the next linear layer consumes. It sits between consecutive linear layers (e.g. 784→20 then 20→10) and replaces a parallel-to-serial glue path. There is no backpressure; downstream always accepts.

## Interface
Parameters:
- DATA_WIDTH, 24, element width, two's-complement fixed point
- NUM_NODES, 20, vector length (≥2)
- RELU_EN, 1, 1 = clamp negative elements to 0; 0 = pass through unchanged

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- i_valid  in  1  one-cycle pulse: din holds a complete vector
- din  in  [DATA_WIDTH-1:0] x NUM_NODES (unpacked)  parallel vector from upstream layer
- dout  out  DATA_WIDTH  current serialized element
- o_valid  out  1  dout valid this cycle
- o_last  out  1  high with o_valid on element NUM_NODES-1
- o_busy  out  1  high while a stream is in progress (state STREAM)
- o_overrun  out  1  one-cycle pulse: an i_valid was dropped

## Operation
- Vector buffer: NUM_NODES x DATA_WIDTH registers, loaded only on an accepted i_valid.
- ReLU is applied at capture. Element is negative when MSB=1 → stored as 0. Otherwise stored unchanged. With RELU_EN=0, store as-is. No width change.
- Index counter idx is $clog2(NUM_NODES) bits and counts 0..NUM_NODES-1. It never wraps past NUM_NODES-1.
- FSM states:
  - IDLE: i_valid → capture the vector, idx←0, go to STREAM.
  - STREAM: present buf[idx] each cycle.
    - idx<NUM_NODES-1: idx++.
    - idx==NUM_NODES-1 and i_valid: capture the new vector, idx←0, stay in STREAM (gapless).
    - idx==NUM_NODES-1 and no i_valid: go to IDLE.
- i_valid in STREAM with idx<NUM_NODES-1:
  - The vector is dropped.
  - The buffer and the stream are unaffected.
  - o_overrun pulses in the next cycle.
- Outputs are registered. dout=0 whenever o_valid=0.

## Timing
- Reset values: dout=0, o_valid=0, o_last=0, o_busy=0, o_overrun=0, idx=0, state IDLE. Buffer contents are don't-care.
- Latency: i_valid sampled in cycle k → o_valid high in cycles k+1..k+NUM_NODES.
  - dout in cycle k+1+j = buf[j].
  - o_last is high in cycle k+NUM_NODES only.
- o_busy is high in cycles k+1..k+NUM_NODES. For a back-to-back accept it stays high continuously.
- Back-to-back: i_valid in cycle k+NUM_NODES (the last output cycle) is accepted. Element 0 of the new vector appears in k+NUM_NODES+1, with no bubble.
- Overrun: i_valid in a cycle where o_busy=1 and o_last=0 → o_overrun=1 exactly one cycle later. Each dropped pulse gives one o_overrun pulse.
- Reset mid-stream: rst sampled high → all outputs 0 next cycle and the stream is aborted. rst dominates a simultaneous i_valid, so that vector is lost and o_overrun is not flagged.
- First i_valid after reset deassertion is accepted normally.
- Throughput: one vector per NUM_NODES cycles maximum.

## Structure
- Shared package mnist_pkg:
  - typedef enum logic {IDLE, STREAM} ser_state_t
  - function relu(input logic signed [DATA_WIDTH-1:0]) parameterized via the package's DATA_WIDTH localparam, so linear/activation stages share one definition.
- No sub-module: a single module with FSM, counter, buffer and output mux. ReLU is invoked as a package function per element in a generate loop at capture.

## Test plan
(NUM_NODES=4, DATA_WIDTH=24 unless noted)
1. Hold rst=1 for 3 cycles with i_valid=1 and random din → all outputs 0 throughout. After release, the first i_valid streams normally.
2. i_valid with din={5, -3 (0xFFFFFD), 0x7FFFFF, 0x800000}, RELU_EN=1 → cycles k+1..k+4 show dout=5, 0, 0x7FFFFF, 0. o_last is high only at k+4, and o_busy=0 at k+5.
3. Same vector with RELU_EN=0 → dout=5, 0xFFFFFD, 0x7FFFFF, 0x800000.
4. Vector A={1,2,3,4} at k, vector B={9,8,7,6} at k+4 → 8 contiguous o_valid cycles k+1..k+8 (1,2,3,4,9,8,7,6). o_last is high at k+4 and k+8, and o_overrun stays 0.
5. Vector A at k, stray i_valid with {0,0,0,0} at k+2 → o_overrun=1 only at k+3. dout is still 1,2,3,4.
6. Vector A at k, rst=1 at k+2 → o_valid=0 and dout=0 from k+3. A new vector at k+5 streams from k+6 starting at element 0.

Source files
------------

// File: rtl/mnist_pkg.sv
// Types and helpers shared by the linear/activation stages of the MNIST pipeline.
package mnist_pkg;

   localparam int DATA_WIDTH = 24;

   typedef enum logic {IDLE, STREAM} ser_state_t;

   function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] x);
      return x[DATA_WIDTH-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/relu_serializer.sv
// Captures a parallel result vector, applies optional ReLU at capture and
// streams the elements out one per cycle, index 0 first.
module relu_serializer #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_NODES  = 20,
   parameter bit RELU_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] din [NUM_NODES],
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  o_valid,
   output logic                  o_last,
   output logic                  o_busy,
   output logic                  o_overrun
);
   import mnist_pkg::*;

   localparam int IDX_W = $clog2(NUM_NODES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

   ser_state_t                    r_state;
   ser_state_t                    w_state_nxt;
   logic        [IDX_W-1:0]       r_idx;
   logic        [IDX_W-1:0]       w_idx_nxt;
   logic                          r_overrun;
   logic                          w_capture;
   logic                          w_drop;
   logic                          w_at_last;
   logic signed [DATA_WIDTH-1:0]  r_buf [NUM_NODES];
   logic signed [DATA_WIDTH-1:0]  w_cap [NUM_NODES];

   for (genvar g = 0; g < NUM_NODES; g++) begin : g_act
      assign w_cap[g] = RELU_EN ? relu(din[g]) : din[g];
   end

   assign w_at_last = (r_idx == LAST_IDX);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_capture   = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_valid) begin
               w_capture   = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (w_at_last) begin
               // A vector arriving on the last output cycle chains without a bubble.
               w_idx_nxt = '0;
               if (i_valid) w_capture   = 1'b1;
               else         w_state_nxt = IDLE;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
               w_drop    = i_valid;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_overrun <= w_drop;
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture) r_buf <= w_cap;
   end

   assign o_busy    = (r_state == STREAM);
   assign o_valid   = o_busy;
   assign o_last    = o_busy && w_at_last;
   assign o_overrun = r_overrun;
   assign dout      = o_busy ? r_buf[r_idx] : '0;

endmodule

// File: tb/tb_relu_serializer.sv
// Directed bench: two serializers (ReLU on / off) driven by the same vectors.
module tb_relu_serializer;

   localparam int DW = 24;
   localparam int NN = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic [DW-1:0] din [NN];
   logic [DW-1:0] dout1, dout0;
   logic          v1, l1, b1, ov1;
   logic          v0, l0, b0, ov0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   relu_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .RELU_EN(1'b1)) u_relu (
      .clk(clk), .rst(rst), .i_valid(i_valid), .din(din),
      .dout(dout1), .o_valid(v1), .o_last(l1), .o_busy(b1), .o_overrun(ov1));

   relu_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .RELU_EN(1'b0)) u_pass (
      .clk(clk), .rst(rst), .i_valid(i_valid), .din(din),
      .dout(dout0), .o_valid(v0), .o_last(l0), .o_busy(b0), .o_overrun(ov0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks the ReLU instance fully plus the pass-through instance's data/valid.
   task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d1,
                             input logic [DW-1:0] d0, input logic last, input logic busy,
                             input logic ovr);
      chk({tag, ".valid"},   {23'd0, v1},  {23'd0, v});
      chk({tag, ".dout"},    dout1,        d1);
      chk({tag, ".last"},    {23'd0, l1},  {23'd0, last});
      chk({tag, ".busy"},    {23'd0, b1},  {23'd0, busy});
      chk({tag, ".overrun"}, {23'd0, ov1}, {23'd0, ovr});
      chk({tag, ".p_valid"}, {23'd0, v0},  {23'd0, v});
      chk({tag, ".p_dout"},  dout0,        d0);
      chk({tag, ".p_last"},  {23'd0, l0},  {23'd0, last});
   endtask

   task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
      din[0] = a; din[1] = b; din[2] = c; din[3] = d;
      i_valid = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      i_valid = 1'b1;
      for (int i = 0; i < NN; i++) din[i] = DW'($urandom);

      // Reset held with i_valid active: everything stays quiet.
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NN; i++) din[i] = DW'($urandom);
         tick();
         expect_out("rst_hold", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b0;
      i_valid = 1'b0;
      tick();
      expect_out("idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Signed boundary vector, first accept after reset.
      load(24'd5, 24'hFFFFFD, 24'h7FFFFF, 24'h800000);
      tick();
      i_valid = 1'b0;
      expect_out("relu_e0", 1'b1, 24'd5,     24'd5,     1'b0, 1'b1, 1'b0);
      tick();
      expect_out("relu_e1", 1'b1, 24'd0,     24'hFFFFFD, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("relu_e2", 1'b1, 24'h7FFFFF, 24'h7FFFFF, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("relu_e3", 1'b1, 24'd0,     24'h800000, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("relu_end", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Back-to-back vectors: B accepted on A's last cycle.
      load(24'd1, 24'd2, 24'd3, 24'd4);
      tick();
      i_valid = 1'b0;
      expect_out("b2b_a0", 1'b1, 24'd1, 24'd1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("b2b_a1", 1'b1, 24'd2, 24'd2, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("b2b_a2", 1'b1, 24'd3, 24'd3, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("b2b_a3", 1'b1, 24'd4, 24'd4, 1'b1, 1'b1, 1'b0);
      load(24'd9, 24'd8, 24'd7, 24'd6);
      tick();
      i_valid = 1'b0;
      expect_out("b2b_b0", 1'b1, 24'd9, 24'd9, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("b2b_b1", 1'b1, 24'd8, 24'd8, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("b2b_b2", 1'b1, 24'd7, 24'd7, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("b2b_b3", 1'b1, 24'd6, 24'd6, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("b2b_end", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Stray i_valid mid-stream is dropped and flagged one cycle later.
      load(24'd1, 24'd2, 24'd3, 24'd4);
      tick();
      i_valid = 1'b0;
      expect_out("ovr_e0", 1'b1, 24'd1, 24'd1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("ovr_e1", 1'b1, 24'd2, 24'd2, 1'b0, 1'b1, 1'b0);
      load(24'd0, 24'd0, 24'd0, 24'd0);
      tick();
      i_valid = 1'b0;
      expect_out("ovr_e2", 1'b1, 24'd3, 24'd3, 1'b0, 1'b1, 1'b1);
      chk("ovr_p_flag", {23'd0, ov0}, 24'd1);
      tick();
      expect_out("ovr_e3", 1'b1, 24'd4, 24'd4, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("ovr_end", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // Reset mid-stream, coinciding with an i_valid that must be lost silently.
      load(24'd1, 24'd2, 24'd3, 24'd4);
      tick();
      i_valid = 1'b0;
      expect_out("mrst_e0", 1'b1, 24'd1, 24'd1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("mrst_e1", 1'b1, 24'd2, 24'd2, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      load(24'd11, 24'd12, 24'd13, 24'd14);
      tick();
      rst = 1'b0;
      i_valid = 1'b0;
      expect_out("mrst_k3", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("mrst_k4", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("mrst_k5", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      load(24'd9, 24'h800001, 24'd7, 24'd6);
      tick();
      i_valid = 1'b0;
      expect_out("mrst_n0", 1'b1, 24'd9, 24'd9,      1'b0, 1'b1, 1'b0);
      tick();
      expect_out("mrst_n1", 1'b1, 24'd0, 24'h800001, 1'b0, 1'b1, 1'b0);
      tick();
      expect_out("mrst_n2", 1'b1, 24'd7, 24'd7,      1'b0, 1'b1, 1'b0);
      tick();
      expect_out("mrst_n3", 1'b1, 24'd6, 24'd6,      1'b1, 1'b1, 1'b0);
      tick();
      expect_out("mrst_end", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
